io_n_bidir_frame_cfg: RTL
=========================

IO_N_BIDIR_FRAME_CFG -- requirements
Module: io_n_bidir_frame_cfg

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 2, number of bidirectional pad channels (1..5).
REQ-002 The block SHALL have parameter FRAME_BITS, default 32, width of FrameData.
REQ-003 The block SHALL have parameter FRAMES, default 20, width of FrameStrobe.
REQ-004 The block SHALL have parameter MODE_FRAME, default 0, FrameStrobe index that loads the mode word.
REQ-005 The block SHALL have parameter CA_FRAME, default 1, FrameStrobe index that loads the config-access word.
REQ-006 The block SHALL have port UserCLK, input, 1, the single clock; all flops rise-edge triggered.
REQ-007 The block SHALL have port UserRSTn, input, 1; reset is synchronous and active-low.
REQ-008 The block SHALL have port FrameData, input, FRAME_BITS, configuration data.
REQ-009 The block SHALL have port FrameStrobe, input, FRAMES, per-frame write strobes, level-sampled each edge.
REQ-010 The block SHALL have port O_top, input, CHANNELS, pad-to-fabric data.
REQ-011 The block SHALL have port I_top, output, CHANNELS, fabric-to-pad data.
REQ-012 The block SHALL have port T_top, output, CHANNELS, pad tristate; 1 = high-Z.
REQ-013 The block SHALL have port I, input, CHANNELS, output data from the switch matrix.
REQ-014 The block SHALL have port T, input, CHANNELS, tristate request from the switch matrix.
REQ-015 The block SHALL have port O, output, CHANNELS, mode-selected input data to the fabric.
REQ-016 The block SHALL have port Q, output, CHANNELS, O_top registered once.
REQ-017 The block SHALL have port C_bits, output, 4*CHANNELS, config-access bits; channel n uses [4n+3:4n].
REQ-018 The block SHALL have port cfg_valid, output, 1, both frames loaded since reset.

Function
REQ-019 Mode word SHALL be FrameData[6*CHANNELS-1:0], 6 bits per channel n at [6n+5:6n]: [1:0] in_mode, [2] out_reg, [3] tri_reg, [4] out_inv, [5] oe_kill.
REQ-020 Elaboration SHALL fail when 6*CHANNELS > FRAME_BITS, MODE_FRAME = CA_FRAME, or either index >= FRAMES.
REQ-021 When FrameStrobe[MODE_FRAME]=1 at an edge, the mode register SHALL capture the mode word, effective from the next cycle.
REQ-022 When FrameStrobe[CA_FRAME]=1 at an edge, the C_bits register SHALL capture FrameData[4*CHANNELS-1:0]; bits above it SHALL be ignored.
REQ-023 Both strobes high in the same edge SHALL load both registers from the same FrameData.
REQ-024 The mode_seen and ca_seen sticky flags SHALL set on their load; cfg_valid = mode_seen AND ca_seen, registered.
REQ-025 cfg_valid SHALL be 1 starting the cycle after the later of the two loads.
REQ-026 Reloading either frame SHALL NOT clear cfg_valid or flush data pipelines; the new mode SHALL apply from the next cycle.
REQ-027 Q[n] SHALL be O_top[n] delayed one cycle in every mode.
REQ-028 O[n] by in_mode: 0 = O_top[n] combinational; 1 = Q[n] (1 cycle); 2 or 3 = second synchroniser flop (2 cycles).
REQ-029 The drive value SHALL be d = I[n] XOR out_inv; I_top[n] SHALL be d registered when out_reg=1, else d combinational.
REQ-030 The tristate value SHALL be t = T[n] OR oe_kill; T_top[n] SHALL be t registered when tri_reg=1, else t combinational.
REQ-031 While cfg_valid=0, T_top SHALL be forced to all-ones and I_top to zero, regardless of I/T.
REQ-032 Channels SHALL be fully independent; no cross-channel logic beyond the shared config registers.

Reset
REQ-033 On an edge with UserRSTn=0, mode register, C_bits, mode_seen, ca_seen, cfg_valid, Q, and the sync and I_top flops SHALL become 0; the T_top flops SHALL become 1.
REQ-034 Reset SHALL take priority over a simultaneous FrameStrobe; that frame is lost.
REQ-035 Reset asserted mid-operation SHALL return T_top to all-ones and I_top to zero by the cycle after the reset edge.

Verification
REQ-036 CHANNELS=2: reset, strobe MODE_FRAME only with FrameData=0 -> cfg_valid stays 0, T_top=2'b11, I_top=2'b00 while I=2'b11, T=2'b00.
REQ-037 Strobe CA_FRAME with FrameData=32'h0000_00A5 -> C_bits=8'hA5 next cycle and cfg_valid=1 the cycle after that.
REQ-038 Channel 0 mode 6'b000010, pulse O_top[0] 0->1 at cycle k -> Q[0] rises at k+1 and O[0] rises at k+2; with in_mode=0, O[0] follows O_top[0] in the same cycle.
REQ-039 Channel 1 out_reg=1, out_inv=1, I[1]=0 -> I_top[1]=1 one cycle later; set oe_kill=1, tri_reg=0 -> T_top[1]=1 while T[1]=0.
REQ-040 Both strobes in one edge with FrameData=32'hFFFF_FFFF -> cfg_valid=1 two cycles later; assert UserRSTn=0 with a strobe in the same edge -> all registers at reset values, cfg_valid=0.

Source files
------------

// File: rtl/io_n_bidir_frame_cfg.sv
// -----------------------------------------------------------------------------
// io_n_bidir_frame_cfg
//
// N-channel bidirectional pad adapter whose behaviour is set by two
// configuration frames delivered over FrameData/FrameStrobe.
//
// Handshake note: there is no valid/ready pair here. A frame is accepted on
// every rising edge where its FrameStrobe bit is high (level sampled, no
// back-pressure). cfg_valid reports that both frames have been accepted since
// the last reset; until then the pads are held safe (tristated, driving 0).
//
// Parameters
//   CHANNELS   number of pad channels (1..5)
//   FRAME_BITS width of FrameData
//   FRAMES     width of FrameStrobe
//   MODE_FRAME strobe index that loads the mode word
//   CA_FRAME   strobe index that loads the config-access word
//
// Ports
//   UserCLK     clock, rising edge
//   UserRSTn    synchronous active-low reset
//   FrameData   configuration data
//   FrameStrobe per-frame write strobes
//   O_top       pad -> fabric data
//   I_top       fabric -> pad data
//   T_top       pad tristate (1 = high-Z)
//   I, T        drive data / tristate request from the switch matrix
//   O           mode-selected input data to the fabric
//   Q           O_top registered once
//   C_bits      config-access bits, channel n at [4n+3:4n]
//   cfg_valid   both frames loaded since reset
//
// Mode word, 6 bits per channel at [6n+5:6n]:
//   [1:0] in_mode  0 = direct, 1 = one flop, 2/3 = two-flop synchroniser
//   [2]   out_reg  register the drive value
//   [3]   tri_reg  register the tristate value
//   [4]   out_inv  invert the drive value
//   [5]   oe_kill  force high-Z
// -----------------------------------------------------------------------------
module io_n_bidir_frame_cfg #(
  parameter int CHANNELS   = 2,
  parameter int FRAME_BITS = 32,
  parameter int FRAMES     = 20,
  parameter int MODE_FRAME = 0,
  parameter int CA_FRAME   = 1
) (
  input  logic                    UserCLK,
  input  logic                    UserRSTn,
  input  logic [FRAME_BITS-1:0]   FrameData,
  input  logic [FRAMES-1:0]       FrameStrobe,
  input  logic [CHANNELS-1:0]     O_top,
  output logic [CHANNELS-1:0]     I_top,
  output logic [CHANNELS-1:0]     T_top,
  input  logic [CHANNELS-1:0]     I,
  input  logic [CHANNELS-1:0]     T,
  output logic [CHANNELS-1:0]     O,
  output logic [CHANNELS-1:0]     Q,
  output logic [4*CHANNELS-1:0]   C_bits,
  output logic                    cfg_valid
);

  localparam int MW = 6 * CHANNELS;
  localparam int CW = 4 * CHANNELS;

  // Reject configurations that cannot be wired up consistently.
  if (CHANNELS < 1 || CHANNELS > 5) begin : g_bad_channels
    $error("io_n_bidir_frame_cfg: CHANNELS must be 1..5");
  end
  if (MW > FRAME_BITS) begin : g_bad_width
    $error("io_n_bidir_frame_cfg: mode word does not fit in FrameData");
  end
  if (MODE_FRAME == CA_FRAME) begin : g_bad_same
    $error("io_n_bidir_frame_cfg: MODE_FRAME and CA_FRAME must differ");
  end
  if (MODE_FRAME >= FRAMES || CA_FRAME >= FRAMES ||
      MODE_FRAME < 0 || CA_FRAME < 0) begin : g_bad_index
    $error("io_n_bidir_frame_cfg: frame index out of range");
  end

  logic [MW-1:0]       r_mode;
  logic [CW-1:0]       r_cbits;
  logic                r_mode_seen;
  logic                r_ca_seen;
  logic                r_cfg_valid;
  logic [CHANNELS-1:0] r_q;     // first synchroniser stage, also Q
  logic [CHANNELS-1:0] r_s2;    // second synchroniser stage
  logic [CHANNELS-1:0] r_i;     // registered drive value
  logic [CHANNELS-1:0] r_t;     // registered tristate value

  logic                w_load_mode;
  logic                w_load_ca;
  logic [CHANNELS-1:0] w_d;
  logic [CHANNELS-1:0] w_t;
  logic                w_unused;

  assign w_load_mode = FrameStrobe[MODE_FRAME];
  assign w_load_ca   = FrameStrobe[CA_FRAME];

  // Upper FrameData bits and the other strobes belong to other tiles.
  assign w_unused = &{1'b0, FrameData, FrameStrobe};

  always_ff @(posedge UserCLK) begin
    if (!UserRSTn) begin
      r_mode      <= '0;
      r_cbits     <= '0;
      r_mode_seen <= 1'b0;
      r_ca_seen   <= 1'b0;
      r_cfg_valid <= 1'b0;
      r_q         <= '0;
      r_s2        <= '0;
      r_i         <= '0;
      r_t         <= '1;
    end else begin
      if (w_load_mode) begin
        r_mode      <= FrameData[MW-1:0];
        r_mode_seen <= 1'b1;
      end
      if (w_load_ca) begin
        r_cbits   <= FrameData[CW-1:0];
        r_ca_seen <= 1'b1;
      end
      // Registered from the flags, so it trails the later load by one cycle.
      r_cfg_valid <= r_mode_seen & r_ca_seen;
      r_q         <= O_top;
      r_s2        <= r_q;
      r_i         <= w_d;
      r_t         <= w_t;
    end
  end

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    logic [1:0] w_in_mode;
    logic       w_out_reg;
    logic       w_tri_reg;
    logic       w_out_inv;
    logic       w_oe_kill;

    assign w_in_mode = r_mode[6*n +: 2];
    assign w_out_reg = r_mode[6*n + 2];
    assign w_tri_reg = r_mode[6*n + 3];
    assign w_out_inv = r_mode[6*n + 4];
    assign w_oe_kill = r_mode[6*n + 5];

    assign w_d[n] = I[n] ^ w_out_inv;
    assign w_t[n] = T[n] | w_oe_kill;

    assign O[n] = (w_in_mode == 2'd0) ? O_top[n] :
                  (w_in_mode == 2'd1) ? r_q[n]   : r_s2[n];

    // Until configured, pads are held high-Z and driving 0.
    assign I_top[n] = r_cfg_valid & (w_out_reg ? r_i[n] : w_d[n]);
    assign T_top[n] = ~r_cfg_valid | (w_tri_reg ? r_t[n] : w_t[n]);
  end

  assign Q         = r_q;
  assign C_bits    = r_cbits;
  assign cfg_valid = r_cfg_valid;

endmodule
